mem_stall_bridge: RTL and testbench
===================================

# mem_stall_bridge

Multi-cycle bridge between the single-cycle core's data-memory port (ALU_Result address, Read_Data_2 write data, MemRead/MemWrite strobes) and an external valid/ready memory bus with variable latency. It sits directly downstream of the core in place of the single-cycle data memory and raises a stall that freezes the PC register and register-file write until the access completes. A per-access timeout counter guarantees forward progress if the bus never responds.

## Interface
- TIMEOUT, 255, max cycles spent in REQ+WAIT_RSP before forced completion (1..65535)
- ERR_DATA, 32'hDEADBEEF, read data returned on timeout
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- cpu_addr  input  32  byte address from ALU result
- cpu_wdata  input  32  store data from register file port 2
- cpu_mem_read  input  1  load strobe from control
- cpu_mem_write  input  1  store strobe from control
- cpu_rdata  output  32  registered load data, valid in DONE
- cpu_stall  output  1  combinational; high holds PC and blocks RegWrite
- ext_req_valid  output  1  request valid
- ext_req_ready  input  1  bus accepts request
- ext_we  output  1  1 = write, 0 = read
- ext_addr  output  32  latched address
- ext_wdata  output  32  latched store data
- ext_rsp_valid  input  1  response/ack valid
- ext_rsp_data  input  32  read data
- ext_rsp_error  input  1  bus error with response
- bus_err  output  1  sticky: error response or timeout seen
- timed_out  output  1  sticky: timeout occurred

## Operation
- States IDLE, REQ, WAIT_RSP, DONE.
- IDLE: access = cpu_mem_read | cpu_mem_write. On access: latch addr, wdata, we = cpu_mem_write (write wins if both high), clear counter, go REQ.
- REQ: ext_req_valid=1; addr/wdata/we held stable until ext_req_ready. On ready go WAIT_RSP. ext_rsp_valid ignored in REQ.
- WAIT_RSP: on ext_rsp_valid capture ext_rsp_data into cpu_rdata (reads and writes alike), set bus_err if ext_rsp_error, go DONE.
- Timeout: counter increments each cycle in REQ or WAIT_RSP; when count == TIMEOUT-1 and no completing event that cycle, drop request, load cpu_rdata=ERR_DATA, set bus_err and timed_out, go DONE. Response in the same cycle as expiry wins.
- DONE: one cycle, cpu_stall=0 so the core retires the instruction; next state IDLE unconditionally (new access detected next cycle).
- cpu_stall = access & (state != DONE).
- Late ext_rsp_valid in IDLE/DONE/REQ ignored.
- bus_err/timed_out clear only on rst.

## Timing
- Reset values: state IDLE, cpu_rdata 0, ext_req_valid 0, ext_we 0, ext_addr 0, ext_wdata 0, counter 0, bus_err 0, timed_out 0.
- Minimum access: 4 cycles (IDLE detect, REQ with ready, WAIT_RSP with rsp, DONE); 3 stall cycles.
- Each extra cycle of ready or response delay adds one stall cycle.
- Reset mid-access: next edge returns to IDLE, ext_req_valid low; outstanding response discarded.
- Non-memory instruction: cpu_stall=0, zero overhead.

## Structure
- Shared package mips_pkg: bridge state enum, ERR_DATA default, TIMEOUT default.
- One sub-module: bus_timeout_counter (clear, enable, expire output, width from TIMEOUT).
- Remainder (FSM, request latches, rdata register, sticky flags) in top.

## Test plan
- Read, ready held high, rsp 1 cycle after acceptance with data 32'h12345678 -> stall high 3 cycles, cpu_rdata=32'h12345678 in DONE, ext_we=0.
- Write addr 32'h40 data 32'hCAFEF00D, ready delayed 3 cycles -> ext_addr/ext_wdata stable through REQ, ext_we=1, stall 6 cycles, bus_err=0.
- Read with no response, TIMEOUT=8 -> DONE after 8 REQ/WAIT cycles, cpu_rdata=32'hDEADBEEF, bus_err=1, timed_out=1.
- Response with ext_rsp_error=1 -> bus_err=1, timed_out=0, data still captured; flags persist until rst.
- rst asserted in WAIT_RSP, response arrives after reset -> state IDLE, ext_req_valid=0, cpu_rdata=0, response ignored.
- Read and write strobes both high -> ext_we=1; back-to-back loads each take 4 cycles.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and defaults for the core's data-memory bridge.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DONE     = 2'd3
  } bridge_state_t;

  localparam int unsigned TIMEOUT_DEF  = 255;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

  // Counter width able to hold 0..t-1 (at least one bit).
  function automatic int cnt_width(input int unsigned t);
    return (t > 1) ? $clog2(t) : 1;
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Per-access cycle counter; expire flags the last permitted cycle.
module bus_timeout_counter
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = cnt_width(TIMEOUT);

  logic [CW-1:0] cnt;

  // Count cycles while enabled; clear restarts the budget for a new access.
  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (enable)  cnt <= cnt + 1'b1;
  end

  assign expire = enable && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stall_bridge.sv
// Stalls the single-cycle core while a data access runs on a valid/ready bus.
module mem_stall_bridge
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_mem_read,
  input  logic        cpu_mem_write,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        ext_req_valid,
  input  logic        ext_req_ready,
  output logic        ext_we,
  output logic [31:0] ext_addr,
  output logic [31:0] ext_wdata,
  input  logic        ext_rsp_valid,
  input  logic [31:0] ext_rsp_data,
  input  logic        ext_rsp_error,
  output logic        bus_err,
  output logic        timed_out
);

  bridge_state_t state_q, state_d;
  logic access, expire, cnt_clr, cnt_en, rsp_evt, tmo_evt;

  assign access  = cpu_mem_read | cpu_mem_write;
  assign cnt_en  = (state_q == ST_REQ) || (state_q == ST_WAIT_RSP);
  assign cnt_clr = (state_q == ST_IDLE) && access;
  // A response in the expiry cycle completes normally; only WAIT_RSP accepts one.
  assign rsp_evt = (state_q == ST_WAIT_RSP) && ext_rsp_valid;
  assign tmo_evt = expire && !rsp_evt;

  bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clr),
    .enable (cnt_en),
    .expire (expire)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; timeout in REQ wins over a same-cycle ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (access) state_d = ST_REQ;
      ST_REQ:      if (expire) state_d = ST_DONE;
                   else if (ext_req_ready) state_d = ST_WAIT_RSP;
      ST_WAIT_RSP: if (rsp_evt || tmo_evt) state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; DONE releases the core for one cycle.
  always_comb begin
    ext_req_valid = (state_q == ST_REQ);
    cpu_stall     = access && (state_q != ST_DONE);
  end

  // Request latches, load data register and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_we    <= 1'b0;
      ext_addr  <= '0;
      ext_wdata <= '0;
      cpu_rdata <= '0;
      bus_err   <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      if (cnt_clr) begin
        ext_we    <= cpu_mem_write;
        ext_addr  <= cpu_addr;
        ext_wdata <= cpu_wdata;
      end
      if (rsp_evt) begin
        cpu_rdata <= ext_rsp_data;
        if (ext_rsp_error) bus_err <= 1'b1;
      end else if (tmo_evt) begin
        cpu_rdata <= ERR_DATA;
        bus_err   <= 1'b1;
        timed_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stall_bridge.sv
// Scoreboard bench for mem_stall_bridge with a scripted bus responder.
module tb_mem_stall_bridge;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_mem_read = 1'b0, cpu_mem_write = 1'b0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall, ext_req_valid, ext_we, bus_err, timed_out;
  logic        ext_req_ready = 1'b0, ext_rsp_valid = 1'b0, ext_rsp_error = 1'b0;
  logic [31:0] ext_addr, ext_wdata;
  logic [31:0] ext_rsp_data = '0;

  mem_stall_bridge #(.TIMEOUT(TMO), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_mem_read  (cpu_mem_read),
    .cpu_mem_write (cpu_mem_write),
    .cpu_rdata     (cpu_rdata),
    .cpu_stall     (cpu_stall),
    .ext_req_valid (ext_req_valid),
    .ext_req_ready (ext_req_ready),
    .ext_we        (ext_we),
    .ext_addr      (ext_addr),
    .ext_wdata     (ext_wdata),
    .ext_rsp_valid (ext_rsp_valid),
    .ext_rsp_data  (ext_rsp_data),
    .ext_rsp_error (ext_rsp_error),
    .bus_err       (bus_err),
    .timed_out     (timed_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata, addr, wdata;
    logic        we, berr, tmo;
    int          stalls;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0, errors = 0, stall_n = 0;
  logic m_berr = 1'b0, m_tmo = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Monitor: count stall cycles, compare against the scoreboard on DONE.
  always @(negedge clk) begin
    if (rst) stall_n = 0;
    else if (cpu_stall) stall_n++;
    else if (cpu_mem_read || cpu_mem_write) begin
      if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        mon_e = sb.pop_front();
        chk("rdata",     cpu_rdata, mon_e.rdata);
        chk("we",        ext_we,    mon_e.we);
        chk("addr",      ext_addr,  mon_e.addr);
        chk("wdata",     ext_wdata, mon_e.wdata);
        chk("bus_err",   bus_err,   mon_e.berr);
        chk("timed_out", timed_out, mon_e.tmo);
        chk("stalls",    stall_n,   mon_e.stalls);
      end
      stall_n = 0;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; cpu_mem_read = 1'b0; cpu_mem_write = 1'b0;
    ext_req_ready = 1'b0; ext_rsp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_berr = 1'b0; m_tmo = 1'b0;
  endtask

  // One core access; the bench plays the bus with the given ready/response delays.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int rdy_dly, input int rsp_dly,
                        input bit rsp_on, input bit err, input logic [31:0] rdata,
                        input bit hold);
    exp_t e;
    int nreq, nwait;
    bit acc, done;
    e.addr  = addr;
    e.wdata = wdata;
    e.we    = wr;
    e.rdata = rsp_on ? rdata : 32'hDEADBEEF;
    m_berr  = m_berr | (rsp_on ? err : 1'b1);
    m_tmo   = m_tmo | !rsp_on;
    e.berr  = m_berr;
    e.tmo   = m_tmo;
    e.stalls = rsp_on ? (1 + (rdy_dly + 1) + (rsp_dly + 1)) : (1 + int'(TMO));
    sb.push_back(e);

    @(posedge clk); #1;
    cpu_mem_read = rd; cpu_mem_write = wr; cpu_addr = addr; cpu_wdata = wdata;
    nreq = 0; nwait = 0; acc = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk); #1;
      if (!cpu_stall) begin
        done = 1; ext_req_ready = 1'b0; ext_rsp_valid = 1'b0;
      end else if (ext_req_valid) begin
        chk("req_addr",  ext_addr,  addr);
        chk("req_wdata", ext_wdata, wdata);
        chk("req_we",    ext_we,    wr);
        ext_req_ready = (nreq >= rdy_dly);
        acc = ext_req_ready;
        ext_rsp_valid = 1'b0;
        nreq++;
      end else if (acc) begin
        ext_req_ready = 1'b0;
        ext_rsp_valid = rsp_on && (nwait == rsp_dly);
        ext_rsp_data  = rdata;
        ext_rsp_error = err;
        nwait++;
      end
    end
    if (!done) chk("done_budget", 32'd0, 32'd1);
    @(negedge clk); #1;
    if (!hold) begin cpu_mem_read = 1'b0; cpu_mem_write = 1'b0; end
  endtask

  initial begin
    do_reset();
    // Reset state and a non-memory instruction with garbage address.
    cpu_addr = 32'h1234; cpu_wdata = 32'h5678;
    repeat (2) @(negedge clk);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_valid", ext_req_valid, 1'b0);
    chk("rst_we",    ext_we, 1'b0);
    chk("rst_addr",  ext_addr, 32'h0);
    chk("rst_wdata", ext_wdata, 32'h0);
    chk("rst_berr",  bus_err, 1'b0);
    chk("rst_tmo",   timed_out, 1'b0);
    chk("nomem_stall", cpu_stall, 1'b0);

    // Fastest read, delayed-ready write, then a read that never gets a response.
    access(1, 0, 32'h100, 32'h0,        0, 0, 1, 0, 32'h12345678, 0);
    access(0, 1, 32'h40,  32'hCAFEF00D, 3, 0, 1, 0, 32'h0,        0);
    access(1, 0, 32'h80,  32'h0,        0, 0, 0, 0, 32'h0,        0);

    // Error response keeps data and sets only bus_err; flag survives a clean access.
    do_reset();
    access(1, 0, 32'h200, 32'h0, 0, 2, 1, 1, 32'hA5A5A5A5, 0);
    access(1, 0, 32'h204, 32'h0, 1, 0, 1, 0, 32'h11112222, 0);

    // Reset while waiting for a response; the late response must be dropped.
    @(posedge clk); #1;
    cpu_mem_read = 1'b1; cpu_addr = 32'h300; ext_req_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ext_req_ready = 1'b0;
    chk("mid_stall", cpu_stall, 1'b1);
    rst = 1'b1; cpu_mem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; m_berr = 1'b0; m_tmo = 1'b0;
    ext_rsp_valid = 1'b1; ext_rsp_data = 32'h55555555;
    chk("mid_valid", ext_req_valid, 1'b0);
    chk("mid_rdata", cpu_rdata, 32'h0);
    @(posedge clk); #1;
    ext_rsp_valid = 1'b0;
    chk("late_rdata", cpu_rdata, 32'h0);
    chk("late_berr",  bus_err, 1'b0);
    chk("late_stall", cpu_stall, 1'b0);

    // Both strobes high is a write; then back-to-back loads with no gap cycle.
    access(1, 1, 32'h400, 32'h0BADF00D, 1, 1, 1, 0, 32'h77, 0);
    access(1, 0, 32'h500, 32'h0, 0, 0, 1, 0, 32'hAAAA0001, 1);
    access(1, 0, 32'h504, 32'h0, 0, 0, 1, 0, 32'hAAAA0002, 1);
    access(1, 0, 32'h508, 32'h0, 0, 0, 1, 0, 32'hAAAA0003, 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
